// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode encodings, flag bit positions and controller states for alu_mc.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [3:0] C_OP_NOP = 4'b0000;
    localparam logic [3:0] C_OP_LDO = 4'b0001;
    localparam logic [3:0] C_OP_LDA = 4'b0010;
    localparam logic [3:0] C_OP_LDR = 4'b0011;
    localparam logic [3:0] C_OP_PRE = 4'b0100;
    localparam logic [3:0] C_OP_STO = 4'b0101;
    localparam logic [3:0] C_OP_ADD = 4'b0110;
    localparam logic [3:0] C_OP_SHL = 4'b0111;
    localparam logic [3:0] C_OP_SHR = 4'b1000;
    localparam logic [3:0] C_OP_SAR = 4'b1001;
    localparam logic [3:0] C_OP_INV = 4'b1010;
    localparam logic [3:0] C_OP_AND = 4'b1011;
    localparam logic [3:0] C_OP_OR  = 4'b1100;
    localparam logic [3:0] C_OP_XOR = 4'b1101;
    localparam logic [3:0] C_OP_JMP = 4'b1110;
    localparam logic [3:0] C_OP_HLT = 4'b1111;

    localparam int C_FLAG_CF = 4;
    localparam int C_FLAG_OF = 3;
    localparam int C_FLAG_ZF = 2;
    localparam int C_FLAG_SF = 1;
    localparam int C_FLAG_PF = 0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == C_OP_SHL) || (op == C_OP_SHR) || (op == C_OP_SAR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_shift_unit
// Brief    : Iterative shifter, one bit per step, exposing the next value and
//            the bit that step shifts out.
// Revision : 1.0
// ============================================================================
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   amount,
    output logic             last,
    output logic [WIDTH-1:0] next_value,
    output logic             shifted_out
);

    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_count;
    logic             r_left;
    logic             r_arith;

    assign last = (r_count == SHW'(1));

    always_comb begin
        next_value  = {1'b0, r_work[WIDTH-1:1]};
        shifted_out = r_work[0];
        if (r_left) begin
            next_value  = {r_work[WIDTH-2:0], 1'b0};
            shifted_out = r_work[WIDTH-1];
        end else if (r_arith) begin
            next_value  = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_count <= '0;
            r_left  <= 1'b0;
            r_arith <= 1'b0;
        end else if (load) begin
            r_work  <= data;
            r_count <= amount;
            r_left  <= (op == C_OP_SHL);
            r_arith <= (op == C_OP_SAR);
        end else if (step) begin
            r_work  <= next_value;
            r_count <= r_count - SHW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Brief    : Registered multi-cycle ALU with start/busy/done handshake, a
//            persistent flag register and bit-serial shifts.
// Revision : 1.0
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ins,
    input  logic [WIDTH-1:0] alu_in,
    input  logic [WIDTH-1:0] accum,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic [4:0]       flags
);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_multi;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_shift_value;
    logic             w_shift_out;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_result;
    logic             w_cf;
    logic             w_of;
    logic [WIDTH-1:0] r_alu_out;
    logic [4:0]       r_flags;
    logic             r_done;

    function automatic logic [4:0] pack_flags(input logic cf, input logic of,
                                              input logic [WIDTH-1:0] res);
        return {cf, of, (res == '0), res[WIDTH-1], ^res};
    endfunction

    assign w_sum    = {1'b0, accum} + {1'b0, alu_in};
    assign w_accept = start && (r_state == IDLE);
    assign w_multi  = is_shift(ins) && (shamt != '0);

    // Single-cycle result; zero-count shifts fall through as a plain move of alu_in.
    always_comb begin
        w_result = accum;
        w_cf     = r_flags[C_FLAG_CF];
        w_of     = r_flags[C_FLAG_OF];
        case (ins)
            C_OP_LDO, C_OP_LDA, C_OP_PRE, C_OP_JMP,
            C_OP_SHL, C_OP_SHR, C_OP_SAR: w_result = alu_in;
            C_OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_cf     = w_sum[WIDTH];
                w_of     = (accum[WIDTH-1] == alu_in[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != accum[WIDTH-1]);
            end
            C_OP_INV: begin w_result = ~alu_in;         w_cf = 1'b0; w_of = 1'b0; end
            C_OP_AND: begin w_result = accum & alu_in;  w_cf = 1'b0; w_of = 1'b0; end
            C_OP_OR:  begin w_result = accum | alu_in;  w_cf = 1'b0; w_of = 1'b0; end
            C_OP_XOR: begin w_result = accum ^ alu_in;  w_cf = 1'b0; w_of = 1'b0; end
            default:  w_result = accum;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_multi) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_out <= '0;
            r_flags   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept && !w_multi) begin
                r_alu_out <= w_result;
                r_flags   <= pack_flags(w_cf, w_of, w_result);
                r_done    <= 1'b1;
            end else if (w_step && w_last) begin
                r_alu_out <= w_shift_value;
                r_flags   <= pack_flags(w_shift_out, 1'b0, w_shift_value);
                r_done    <= 1'b1;
            end
        end
    end

    alu_shift_unit #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (w_load),
        .step        (w_step),
        .op          (ins),
        .data        (alu_in),
        .amount      (shamt),
        .last        (w_last),
        .next_value  (w_shift_value),
        .shifted_out (w_shift_out)
    );

    assign busy    = (r_state == SHIFT);
    assign done    = r_done;
    assign alu_out = r_alu_out;
    assign flags   = r_flags;

endmodule
`default_nettype wire
